uart_word_tx: RTL and testbench

//  Serial 8N1 UART transmitter; drives the CPU's io_rx line to download program words into program memory.

---
 rtl/uart_word_tx.sv | 209 ++++++++++++++++++++
 tb/tb_uart_word_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// uart_word_tx
//   Serial UART transmitter used as a program loader / host-link TX.
//   Accepts 32-bit words over a valid/ready handshake and sends each one as
//   four back-to-back frames, least-significant byte first. Each frame is
//   start bit, 8 data bits (LSB first), optional even parity, and
//   STOP_BITS stop bits. io_tx comes straight from a flop.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> an even-parity bit follows the data bits (8E1 / 8E2)
//     undefined -> no parity bit and no parity logic (8N1 / 8N2)
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   word_valid   word_data holds a word to send
//   word_data    word to send, sampled only on the handshake edge
//   word_ready   transmitter idle and able to take a word
//   io_tx        serial output, idle high
//   busy         a word is being transmitted
//   bytes_sent   count of completed bytes, wraps at 16 bits
//
// States
//   IDLE   | line idle high, waiting for a word
//   START  | start bit (low)
//   DATA   | 8 data bits, LSB first
//   PARITY | even parity bit (only with UART_TX_PARITY_EN)
//   STOP   | stop bit(s) (high), then next byte or back to IDLE

module uart_word_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    output logic        word_ready,
    output logic        io_tx,
    output logic        busy,
    output logic [15:0] bytes_sent
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [31:0]      shift_q, shift_d;
    logic             io_tx_q, io_tx_d;
    logic [15:0]      bytes_sent_q, bytes_sent_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic handshake;
    logic bit_end;

    // Ready is forced low during reset so a word can never slip in on a reset edge.
    assign word_ready = (state_q == S_IDLE) && !reset;
    assign handshake  = word_valid && word_ready;
    assign bit_end    = (cnt_q == CNT_LAST);

    assign io_tx      = io_tx_q;
    assign busy       = (state_q != S_IDLE);
    assign bytes_sent = bytes_sent_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            byte_idx_q   <= '0;
            shift_q      <= '0;
            io_tx_q      <= 1'b1;
            bytes_sent_q <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            io_tx_q      <= io_tx_d;
            bytes_sent_q <= bytes_sent_d;
`ifdef UART_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (handshake) state_d = S_START;
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end && (bit_idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end && (bit_idx_q == STOP_LAST)) begin
                    state_d = (byte_idx_q != 2'd3) ? S_START : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output logic
    always_comb begin
        cnt_d        = bit_end ? '0 : cnt_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        bytes_sent_d = bytes_sent_q;
`ifdef UART_TX_PARITY_EN
        parity_d     = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (handshake) begin
                    shift_d    = word_data;
                    byte_idx_d = 2'd0;
                    bit_idx_d  = 3'd0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = 1'b0;
`endif
                end
            end
            S_DATA: begin
                // Shifting the whole word leaves the next byte in [7:0] once
                // the current one is out; bit_idx wraps 7->0 ready for STOP.
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[31:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                    parity_d  = parity_q ^ shift_q[0];
`endif
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == STOP_LAST) begin
                        bit_idx_d    = 3'd0;
                        bytes_sent_d = bytes_sent_q + 16'd1;
                        if (byte_idx_q != 2'd3) byte_idx_d = byte_idx_q + 2'd1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: ;
        endcase

        // io_tx is decoded from the next state so the line changes on the
        // same edge the state does, while still coming from a flop.
        case (state_d)
            S_START:  io_tx_d = 1'b0;
            S_DATA:   io_tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: io_tx_d = parity_d;
`endif
            default:  io_tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_word_tx.sv
module tb_uart_word_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB       = 10 + PAR;        // bits per frame
    localparam int WORD_CYC = 4 * NB * CPB;    // busy cycles per word

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        word_valid = 1'b0;
    logic [31:0] word_data = 32'h0;
    logic        word_ready;
    logic        io_tx;
    logic        busy;
    logic [15:0] bytes_sent;

    int checks = 0;
    int errors = 0;
    int rx_count = 0;
    logic [7:0] exp_q[$];

    uart_word_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .io_tx      (io_tx),
        .busy       (busy),
        .bytes_sent (bytes_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] d);
        for (int i = 0; i < 4; i++) exp_q.push_back(d[8*i +: 8]);
    endtask

    task automatic wait_busy_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    // Word send from idle: checks start latency, word length, count and ready.
    task automatic send_word(input logic [31:0] d, input logic [15:0] exp_sent);
        int n;
        @(posedge clk); #1;
        word_valid = 1'b1;
        word_data  = d;
        push_word(d);
        @(posedge clk); #1;
        word_valid = 1'b0;
        word_data  = ~d;
        @(negedge clk);
        chk("start_latency", io_tx, 1'b0);
        wait_busy_done(n);
        chk("word_cycles", n, WORD_CYC);
        chk("bytes_sent", bytes_sent, exp_sent);
        chk("ready_after_word", word_ready, 1'b1);
    endtask

    // Monitor: decodes frames from io_tx and compares against the scoreboard.
    initial begin
        logic       prev_tx;
        logic       act;
        int         cnt;
        int         k;
        logic [7:0] rx;
        logic       par;
        logic [7:0] e;
        prev_tx = 1'b1;
        act = 1'b0;
        cnt = 0;
        rx = '0;
        par = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                act = 1'b0;
            end else if (!act) begin
                if (prev_tx === 1'b1 && io_tx === 1'b0) begin
                    act = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt++;
                if (cnt >= 2 && ((cnt - 2) % CPB) == 0) begin
                    k = (cnt - 2) / CPB;
                    if (k == 0) begin
                        chk("start_bit", io_tx, 1'b0);
                    end else if (k <= 8) begin
                        rx[k-1] = io_tx;
                    end else if (k == NB - 1) begin
                        chk("stop_bit", io_tx, 1'b1);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rx_unexpected: got %0h expected none", rx);
                        end else begin
                            e = exp_q.pop_front();
                            chk("rx_byte", rx, e);
`ifdef UART_TX_PARITY_EN
                            chk("parity_bit", par, ^e);
`endif
                        end
                        rx_count++;
                        act = 1'b0;
                    end else begin
                        par = io_tx;
                    end
                end
            end
            prev_tx = io_tx;
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int   n;
        logic low_seen;

        // Reset held 3 cycles with word_valid high: nothing may be accepted.
        reset = 1'b1;
        word_valid = 1'b1;
        word_data = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            chk("ready_in_reset", word_ready, 1'b0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        word_valid = 1'b0;
        @(negedge clk);
        chk("reset_io_tx", io_tx, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_bytes_sent", bytes_sent, 16'd0);
        chk("reset_ready", word_ready, 1'b1);

        // Single word
        send_word(32'h0000_00A5, 16'd4);

        // Back-to-back with word_valid held high
        do_reset();
        @(posedge clk); #1;
        word_valid = 1'b1;
        word_data  = 32'h1122_3344;
        push_word(32'h1122_3344);
        @(posedge clk); #1;
        word_data = 32'hDEAD_BEEF;
        push_word(32'hDEAD_BEEF);
        @(negedge clk);
        chk("b2b_start1", io_tx, 1'b0);
        wait_busy_done(n);
        chk("b2b_word1_cycles", n, WORD_CYC);
        chk("b2b_gap_tx", io_tx, 1'b1);
        chk("b2b_gap_ready", word_ready, 1'b1);
        @(posedge clk); #1;
        word_valid = 1'b0;
        word_data  = 32'h0;
        @(negedge clk);
        chk("b2b_single_gap", busy, 1'b1);
        chk("b2b_start2", io_tx, 1'b0);
        wait_busy_done(n);
        chk("b2b_word2_cycles", n, WORD_CYC);
        chk("b2b_bytes_sent", bytes_sent, 16'd8);

        // Reset in the middle of the second byte
        @(posedge clk); #1;
        word_valid = 1'b1;
        word_data  = 32'hCAFE_F00D;
        push_word(32'hCAFE_F00D);
        @(posedge clk); #1;
        word_valid = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_io_tx", io_tx, 1'b1);
        chk("abort_bytes_sent", bytes_sent, 16'd0);
        chk("abort_busy", busy, 1'b0);
        low_seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (io_tx !== 1'b1) low_seen = 1'b1;
        end
        chk("abort_no_restart", low_seen, 1'b0);
        send_word(32'h5A5A_0F01, 16'd4);

        // Parity pattern (odd-weight low byte) and further data patterns
        send_word(32'h0000_0007, 16'd8);
        send_word(32'h80FF_0001, 16'd12);

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("rx_byte_count", rx_count, 25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
